systolic_skew_feeder: RTL and testbench

Upstream feeder for the systolic array's per-path timing and handshake stage. Accepts one row of `NUM_PATHS` operands per valid/ready transfer and re-emits it diagonally skewed: lane `i` is delayed `i` advance cycles relative to lane 0, so operands reach the array on the wavefront it expects. Empty slots are zero-padded bubbles. A tile is framed by `s_last`; the block drains the skew pipeline after the last row and pulses `tile_done` once it has fully left.

---
 rtl/systolic_skew_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: lane i of each accepted row is delayed i advance cycles, tile framed by s_last.
// Optional statistics outputs (stat_rows, stat_stalls) are enabled by defining SKEW_FEEDER_STATS_EN.
module systolic_skew_feeder #(
  parameter int unsigned NUM_PATHS  = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_PATHS*DATA_WIDTH-1:0] s_data,
  input  logic                            s_last,
  input  logic                            m_ready,
  output logic [NUM_PATHS-1:0]            m_valid,
  output logic [NUM_PATHS*DATA_WIDTH-1:0] m_data,
  output logic                            tile_done,
  output logic                            busy
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [31:0]                     stat_rows,
  output logic [31:0]                     stat_stalls
`endif
);

  localparam int unsigned CNT_W = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] drain_cnt_next;
  logic             done_next;
  logic             advance;
  logic             accept;

  // The whole skew array moves as one wavefront, gated only by downstream readiness.
  assign advance = m_ready;
  assign s_ready = rst_n & m_ready & (state != DRAIN);
  assign accept  = s_valid & s_ready;
  assign busy    = (state != IDLE) | (|m_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      tile_done <= done_next;
    end
  end

  // Drain counts the advances still needed for the last row to clear the deepest lane.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    done_next      = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (s_last) begin
            state_next     = DRAIN;
            drain_cnt_next = CNT_W'(NUM_PATHS - 1);
          end else begin
            state_next = STREAM;
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          if (drain_cnt != '0) begin
            drain_cnt_next = drain_cnt - CNT_W'(1);
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane i owns a chain of i+1 stages; bubbles carry zero data so invalid outputs read 0.
  for (genvar i = 0; i < NUM_PATHS; i++) begin : g_lane
    logic [i:0]                 vreg;
    logic [i:0][DATA_WIDTH-1:0] dreg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vreg <= '0;
        dreg <= '0;
      end else if (advance) begin
        vreg[0] <= accept;
        dreg[0] <= accept ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) begin
          vreg[k] <= vreg[k-1];
          dreg[k] <= dreg[k-1];
        end
      end
    end

    assign m_valid[i]                          = vreg[i];
    assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = dreg[i];
  end

`ifdef SKEW_FEEDER_STATS_EN
  // Counters show their value during the tile_done cycle and restart from that cycle's activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rows   <= '0;
      stat_stalls <= '0;
    end else begin
      if (tile_done) begin
        stat_rows <= accept ? 32'd1 : 32'd0;
      end else if (accept && (stat_rows != '1)) begin
        stat_rows <= stat_rows + 32'd1;
      end
      if (tile_done) begin
        stat_stalls <= (!m_ready && busy) ? 32'd1 : 32'd0;
      end else if (!m_ready && busy && (stat_stalls != '1)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (NUM_PATHS=4, DATA_WIDTH=16); stats checks need SKEW_FEEDER_STATS_EN.
module tb_systolic_skew_feeder;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = NP * DW;

  typedef struct {
    logic [DW-1:0] d;
    int            adv;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          m_ready;
  logic [NP-1:0] m_valid;
  logic [W-1:0]  m_data;
  logic          tile_done;
  logic          busy;
`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0]   stat_rows;
  logic [31:0]   stat_stalls;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int adv    = 0;

  exp_t lane_q [NP][$];
  int   done_q [$];

  logic [NP-1:0] prev_mv;
  logic [W-1:0]  prev_md;
  logic          prev_mr;
  logic          prev_rst;

  systolic_skew_feeder #(.NUM_PATHS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .tile_done(tile_done),
    .busy(busy)
`ifdef SKEW_FEEDER_STATS_EN
    ,
    .stat_rows(stat_rows),
    .stat_stalls(stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] row(input int r);
    logic [W-1:0] v;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = DW'(16 * (i + 1) + r);
    return v;
  endfunction

  // Expected results are queued at the handshake: lane i of a row accepted on the
  // advance that makes the count k must be shown at count k+i; tile_done at k+NP.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_ready) adv <= adv + 1;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) lane_q[i].delete();
      done_q.delete();
    end else if (s_valid && s_ready) begin
      for (int i = 0; i < NP; i++)
        lane_q[i].push_back(exp_t'{d: s_data[i*DW +: DW], adv: adv + 1 + i});
      if (s_last) done_q.push_back(adv + 1 + NP);
    end
  end

  // Monitor: pops a lane entry whenever that lane's element is consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        if (m_valid[i]) begin
          if (lane_q[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL lane%0d_unexpected: valid with data 0x%0h, expected no element", i, m_data[i*DW +: DW]);
          end else if (m_ready) begin
            check($sformatf("lane%0d_data", i), 64'(m_data[i*DW +: DW]), 64'(lane_q[i][0].d));
            check($sformatf("lane%0d_timing", i), 64'(adv), 64'(lane_q[i][0].adv));
            void'(lane_q[i].pop_front());
          end
        end else begin
          check($sformatf("lane%0d_bubble_zero", i), 64'(m_data[i*DW +: DW]), 64'd0);
          if (lane_q[i].size() != 0 && lane_q[i][0].adv <= adv) begin
            checks++; errors++;
            $display("FAIL lane%0d_missing: valid=0, expected 0x%0h", i, lane_q[i][0].d);
            void'(lane_q[i].pop_front());
          end
        end
      end
      if (tile_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tile_done_unexpected: got 1, expected 0");
        end else begin
          check("tile_done_timing", 64'(adv), 64'(done_q[0]));
          void'(done_q.pop_front());
        end
      end else if (done_q.size() != 0 && done_q[0] <= adv) begin
        checks++; errors++;
        $display("FAIL tile_done_missing: got 0, expected 1");
        void'(done_q.pop_front());
      end
      if (prev_rst && !prev_mr) begin
        check("stall_frozen_valid", 64'(m_valid), 64'(prev_mv));
        check("stall_frozen_data", m_data, prev_md);
      end
    end
    prev_mv  = m_valid;
    prev_md  = m_data;
    prev_mr  = m_ready;
    prev_rst = rst_n;
  end

  task automatic send_row(input logic [W-1:0] d, input logic last, input logic keep, output int acc);
    int n;
    n   = 0;
    acc = -1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_row_accept: s_ready=0 after 64 cycles, expected 1");
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    if (!keep) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
    end
  endtask

  task automatic wait_done(output int dc, output int lows);
    int n;
    n    = 0;
    lows = 0;
    dc   = -1;
    @(negedge clk);
    while (!tile_done && n < 64) begin
      if (!s_ready) lows++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tile_done) begin
      errors++;
      $display("FAIL wait_done: tile_done=0 after 64 cycles, expected 1");
    end else begin
      dc = cyc;
    end
  endtask

  initial begin
    int c, first, last, c2, dc, lows;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'd1);

    // Four-row tile at full rate: done four cycles after the last row, ready low meanwhile.
    for (int r = 0; r < 4; r++) begin
      send_row(row(r), r == 3, 1'b0, c);
      if (r == 0) first = c;
      last = c;
    end
    check("t1_rows_back_to_back", 64'(last - first), 64'd3);
    wait_done(dc, lows);
    check("t1_done_after_last", 64'(dc - last), 64'd4);
    check("t1_ready_low_cycles", 64'(lows), 64'd4);

    // Same tile with a three-cycle stall while a row is offered.
    send_row(row(0), 1'b0, 1'b0, first);
    send_row(row(1), 1'b0, 1'b0, c);
    s_valid = 1'b1;
    s_data  = row(2);
    m_ready = 1'b0;
    @(negedge clk);
    check("stall_s_ready", 64'(s_ready), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 m_ready = 1'b1;
    send_row(row(2), 1'b0, 1'b0, c);
    send_row(row(3), 1'b1, 1'b0, last);
    wait_done(dc, lows);
    check("t2_done_after_first", 64'(dc - first), 64'd10);

    // Single-row tile.
    send_row({NP{16'hAAAA}}, 1'b1, 1'b0, c);
    wait_done(dc, lows);
    check("t3_done_latency", 64'(dc - c), 64'd4);
    check("t3_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("t3_busy_after", 64'(busy), 64'd0);
    check("t3_s_ready_after", 64'(s_ready), 64'd1);

    // Back-to-back tiles with s_valid held: four ready-low cycles sit between the tiles.
    send_row(64'h0103_0102_0101_0100, 1'b0, 1'b1, c);
    send_row(64'h0113_0112_0111_0110, 1'b1, 1'b1, last);
    send_row(64'h0223_0222_0221_0220, 1'b0, 1'b1, c2);
    check("t4_tile_gap", 64'(c2 - last), 64'd5);
    send_row(64'h0233_0232_0231_0230, 1'b1, 1'b0, last);
    wait_done(dc, lows);
    check("t4_done_after_last", 64'(dc - last), 64'd4);

    // Reset while draining discards the tile and suppresses tile_done.
    send_row(row(5), 1'b1, 1'b0, c);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_m_valid_cleared", 64'(m_valid), 64'd0);
    check("t5_m_data_cleared", m_data, 64'd0);
    check("t5_busy_cleared", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check("t5_no_tile_done", 64'(tile_done), 64'd0);
      @(negedge clk);
    end
    send_row(row(7), 1'b0, 1'b0, first);
    send_row(row(8), 1'b1, 1'b0, last);
    wait_done(dc, lows);
    check("t5_fresh_done", 64'(dc - last), 64'd4);

`ifdef SKEW_FEEDER_STATS_EN
    // Five rows with two stall cycles mid-tile.
    send_row(row(10), 1'b0, 1'b0, c);
    send_row(row(11), 1'b0, 1'b0, c);
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 m_ready = 1'b1;
    send_row(row(12), 1'b0, 1'b0, c);
    send_row(row(13), 1'b0, 1'b0, c);
    send_row(row(14), 1'b1, 1'b0, c);
    wait_done(dc, lows);
    check("stat_rows_at_done", 64'(stat_rows), 64'd5);
    check("stat_stalls_at_done", 64'(stat_stalls), 64'd2);
    @(negedge clk);
    check("stat_rows_cleared", 64'(stat_rows), 64'd0);
    check("stat_stalls_cleared", 64'(stat_stalls), 64'd0);
`endif

    repeat (3) @(negedge clk);
    for (int i = 0; i < NP; i++) check($sformatf("lane%0d_queue_empty", i), 64'(lane_q[i].size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
